// File: rtl/fsm_q3c_multi.sv
// fsm_q3c_multi: N independent copies of the five-state q3c Moore FSM.
// Each channel has its own registered state, advance enable, synchronous
// load, saturating count of z-active cycles and a sticky illegal-state flag.
// The current state of every channel is visible on y for observation.
module fsm_q3c_multi #(
    parameter int N     = 2,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic [N-1:0]       en,
    input  logic               clr,
    input  logic [N-1:0]       ld,
    input  logic [3*N-1:0]     ld_state,
    input  logic [N-1:0]       x,
    output logic [3*N-1:0]     y,
    output logic [N-1:0]       Y0,
    output logic [N-1:0]       z,
    output logic [CNT_W*N-1:0] zcnt,
    output logic               any_z,
    output logic [N-1:0]       illegal
);

    typedef enum logic [2:0] {
        S_000 = 3'b000,
        S_001 = 3'b001,
        S_010 = 3'b010,
        S_011 = 3'b011,
        S_100 = 3'b100,
        S_101 = 3'b101,
        S_110 = 3'b110,
        S_111 = 3'b111
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t           cur_q;
        state_t           f_nxt;
        state_t           nxt;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_nxt;
        logic             ill_q;
        logic             ill_nxt;
        logic             z_c;
        logic             is_ill;

        // Next-state table f(y,x) and Moore output; the three unused codes fall back to 000.
        always_comb begin
            f_nxt  = S_000;
            z_c    = 1'b0;
            is_ill = 1'b0;
            case (cur_q)
                S_000: f_nxt = x[i] ? S_001 : S_000;
                S_001: f_nxt = x[i] ? S_100 : S_001;
                S_010: f_nxt = x[i] ? S_001 : S_010;
                S_011: begin
                    f_nxt = x[i] ? S_010 : S_001;
                    z_c   = 1'b1;
                end
                S_100: begin
                    f_nxt = x[i] ? S_100 : S_011;
                    z_c   = 1'b1;
                end
                default: begin
                    f_nxt  = S_000;
                    is_ill = 1'b1;
                end
            endcase
        end

        // Channel update with priority clr > ld > en > hold; the illegal flag
        // latches whenever an illegal code is observed, whatever ld/en do.
        always_comb begin
            nxt     = cur_q;
            cnt_nxt = cnt_q;
            ill_nxt = ill_q | is_ill;
            if (clr) begin
                nxt     = S_000;
                cnt_nxt = '0;
                ill_nxt = 1'b0;
            end else if (ld[i]) begin
                nxt = state_t'(ld_state[3*i +: 3]);
            end else if (en[i]) begin
                nxt = f_nxt;
                if (z_c && (cnt_q != CNT_MAX)) begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
        end

        // Channel registers, cleared asynchronously.
        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                cur_q <= S_000;
                cnt_q <= '0;
                ill_q <= 1'b0;
            end else begin
                cur_q <= nxt;
                cnt_q <= cnt_nxt;
                ill_q <= ill_nxt;
            end
        end

        assign y[3*i +: 3]         = cur_q;
        assign Y0[i]               = f_nxt[0];
        assign z[i]                = z_c;
        assign zcnt[CNT_W*i +: CNT_W] = cnt_q;
        assign illegal[i]          = ill_q;
    end

    assign any_z = |z;

endmodule
